load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: one RAM byte per cycle, little-endian, sign/zero-extended loads.
// Optional LSU_IO_STALL_EN: stores to the I/O window (addr[17:16] == 2'b11) stall while io_buffer_full.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  memory_op,
  input  logic [31:0] memory_value1,
  input  logic [31:0] memory_value2,
  input  logic [31:0] memory_imm,
  input  logic [2:0]  memory_des,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  output logic        memory_busy,
  output logic [31:0] memory_data,
  output logic [2:0]  memory_des_in
);

  localparam logic [4:0] OpLb  = 5'b10010;
  localparam logic [4:0] OpLh  = 5'b10011;
  localparam logic [4:0] OpLw  = 5'b10100;
  localparam logic [4:0] OpLbu = 5'b10101;
  localparam logic [4:0] OpLhu = 5'b10110;
  localparam logic [4:0] OpSb  = 5'b10111;
  localparam logic [4:0] OpSh  = 5'b11000;
  localparam logic [4:0] OpSw  = 5'b11001;

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [2:0]  des_q, des_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] result_q, result_d;

  logic       req_valid;
  logic       is_store;
  logic [2:0] width;
  logic [2:0] last_k;
  logic [1:0] cap_idx;
  logic       io_stall;

  assign req_valid = (memory_op >= OpLb) && (memory_op <= OpSw);
  assign is_store  = (op_q == OpSb) || (op_q == OpSh) || (op_q == OpSw);
  assign last_k    = width - 3'd1;
  // Byte returned by RAM this cycle belongs to the address driven one cycle earlier.
  assign cap_idx   = k_q[1:0] - 2'd1;

  always_comb begin
    width = 3'd1;
    unique case (op_q)
      OpLh, OpLhu, OpSh: width = 3'd2;
      OpLw, OpSw:        width = 3'd4;
      default:           width = 3'd1;
    endcase
  end

`ifdef LSU_IO_STALL_EN
  assign io_stall = is_store && (addr_q[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= 5'h1f;
      des_q    <= '0;
      sdata_q  <= '0;
      addr_q   <= '0;
      k_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      des_q    <= des_d;
      sdata_q  <= sdata_d;
      addr_q   <= addr_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    des_d    = des_q;
    sdata_d  = sdata_q;
    addr_d   = addr_q;
    k_d      = k_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d     = memory_op;
          des_d    = memory_des;
          sdata_d  = memory_value2;
          addr_d   = memory_value1 + memory_imm;
          k_d      = '0;
          result_d = '0;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (!io_stall) begin
          if (!is_store && (k_q != 3'd0)) result_d[{cap_idx, 3'b000} +: 8] = mem_din;
          k_d = k_q + 3'd1;
          if (k_q == last_k) state_d = is_store ? StDone : StWait;
        end
      end
      StWait: begin
        result_d[{cap_idx, 3'b000} +: 8] = mem_din;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_a         = '0;
    mem_dout      = '0;
    mem_wr        = 1'b0;
    memory_busy   = (state_q != StIdle);
    memory_data   = '0;
    memory_des_in = '0;
    if (state_q == StAccess) begin
      mem_a = addr_q + {29'd0, k_q};
      if (is_store) begin
        mem_dout = sdata_q[{k_q[1:0], 3'b000} +: 8];
        mem_wr   = !io_stall;
      end
    end
    if (state_q == StDone) begin
      memory_des_in = des_q;
      unique case (op_q)
        OpLb:    memory_data = {{24{result_q[7]}}, result_q[7:0]};
        OpLh:    memory_data = {{16{result_q[15]}}, result_q[15:0]};
        OpLw:    memory_data = result_q;
        OpLbu:   memory_data = {24'd0, result_q[7:0]};
        OpLhu:   memory_data = {16'd0, result_q[15:0]};
        default: memory_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 1 KiB byte RAM model (1-cycle read latency).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  memory_op = 5'h1f;
  logic [31:0] memory_value1 = '0, memory_value2 = '0, memory_imm = '0;
  logic [2:0]  memory_des = '0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = '0;
  logic [31:0] mem_a, memory_data;
  logic [7:0]  mem_dout;
  logic        mem_wr, memory_busy;
  logic [2:0]  memory_des_in;

  logic [7:0] ram [1024];
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] OpLb = 5'b10010, OpLh = 5'b10011, OpLw = 5'b10100, OpLbu = 5'b10101;
  localparam logic [4:0] OpLhu = 5'b10110, OpSb = 5'b10111, OpSh = 5'b11000, OpSw = 5'b11001;

  load_store_unit dut (
    .clk           (clk),
    .rst           (rst),
    .memory_op     (memory_op),
    .memory_value1 (memory_value1),
    .memory_value2 (memory_value2),
    .memory_imm    (memory_imm),
    .memory_des    (memory_des),
    .io_buffer_full(io_buffer_full),
    .mem_din       (mem_din),
    .mem_a         (mem_a),
    .mem_dout      (mem_dout),
    .mem_wr        (mem_wr),
    .memory_busy   (memory_busy),
    .memory_data   (memory_data),
    .memory_des_in (memory_des_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Drive a request for exactly one accepting edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [2:0] des);
    @(negedge clk);
    memory_op = op; memory_value1 = v1; memory_value2 = v2; memory_imm = imm; memory_des = des;
    @(posedge clk);
    #1 memory_op = 5'h1f;
  endtask

  // Count negedges after the accepting edge until a completion appears.
  task automatic wait_done(input int max, output int cyc, output logic [31:0] data,
                           output logic [2:0] des);
    cyc = -1; data = '0; des = '0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (memory_des_in != 3'd0) begin
        cyc = i; data = memory_data; des = memory_des_in;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] imm, input logic [2:0] des,
                        input int exp_cyc, input logic [31:0] exp_data);
    int cyc; logic [31:0] d; logic [2:0] t;
    issue(op, v1, v2, imm, des);
    wait_done(20, cyc, d, t);
    check_eq({tag, "_lat"}, cyc, exp_cyc);
    check_eq({tag, "_data"}, d, exp_data);
    check_eq({tag, "_des"}, {29'd0, t}, {29'd0, des});
    @(negedge clk);
    check_eq({tag, "_idle"}, {31'd0, memory_busy}, 32'd0);
  endtask

  initial begin
    int cyc; logic [31:0] d; logic [2:0] t; int seen;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h104] = 8'h78; ram[10'h105] = 8'h56; ram[10'h106] = 8'h34; ram[10'h107] = 8'h12;
    ram[10'h050] = 8'h80; ram[10'h060] = 8'h34; ram[10'h061] = 8'h92; ram[10'h200] = 8'h11;

    #2;
    check_eq("rst_busy", {31'd0, memory_busy}, 32'd0);
    check_eq("rst_wr", {31'd0, mem_wr}, 32'd0);
    check_eq("rst_a", mem_a, 32'd0);
    check_eq("rst_des", {29'd0, memory_des_in}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // LW: address walk, WAIT cycle, single-cycle completion
    issue(OpLw, 32'h100, 32'h0, 32'd4, 3'd3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("lw_addr", mem_a, 32'h104 + k);
      check_eq("lw_wr", {31'd0, mem_wr}, 32'd0);
    end
    @(negedge clk);
    check_eq("lw_wait_des", {29'd0, memory_des_in}, 32'd0);
    check_eq("lw_wait_busy", {31'd0, memory_busy}, 32'd1);
    @(negedge clk);
    check_eq("lw_data", memory_data, 32'h12345678);
    check_eq("lw_des", {29'd0, memory_des_in}, 32'd3);
    @(negedge clk);
    check_eq("lw_after_des", {29'd0, memory_des_in}, 32'd0);
    check_eq("lw_after_data", memory_data, 32'd0);

    run_op("lb",  OpLb,  32'h50, 32'h0, 32'h0, 3'd2, 3, 32'hFFFFFF80);
    run_op("lbu", OpLbu, 32'h50, 32'h0, 32'h0, 3'd4, 3, 32'h00000080);
    run_op("lh",  OpLh,  32'h5F, 32'h0, 32'h1, 3'd1, 4, 32'hFFFF9234);
    run_op("lhu", OpLhu, 32'h60, 32'h0, 32'h0, 3'd7, 4, 32'h00009234);

    // SH with negative offset
    run_op("sh", OpSh, 32'h200, 32'hDEADBEEF, 32'hFFFFFFFE, 3'd5, 3, 32'd0);
    check_eq("sh_b0", {24'd0, ram[10'h1FE]}, 32'hEF);
    check_eq("sh_b1", {24'd0, ram[10'h1FF]}, 32'hBE);
    check_eq("sh_b2", {24'd0, ram[10'h200]}, 32'h11);

    run_op("sw", OpSw, 32'h300, 32'hCAFEBABE, 32'h0, 3'd6, 5, 32'd0);
    run_op("lw2", OpLw, 32'h2F0, 32'h0, 32'h10, 3'd2, 6, 32'hCAFEBABE);

    // Non-listed op is ignored
    issue(5'b00001, 32'h50, 32'h0, 32'h0, 3'd1);
    @(negedge clk);
    check_eq("bad_op_busy", {31'd0, memory_busy}, 32'd0);

    // Request held through busy: second accepted only after the post-DONE IDLE cycle
    @(negedge clk);
    memory_op = OpLbu; memory_value1 = 32'h50; memory_imm = 32'h0; memory_des = 3'd1;
    @(posedge clk);
    #1 memory_value1 = 32'h104; memory_des = 3'd6;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check_eq("b2b_d1_des", {29'd0, memory_des_in}, 32'd1);
    check_eq("b2b_d1_data", memory_data, 32'h80);
    @(negedge clk);
    check_eq("b2b_idle", {31'd0, memory_busy}, 32'd0);
    @(negedge clk);
    check_eq("b2b_busy2", {31'd0, memory_busy}, 32'd1);
    memory_op = 5'h1f;
    @(negedge clk); @(negedge clk);
    check_eq("b2b_d2_des", {29'd0, memory_des_in}, 32'd6);
    check_eq("b2b_d2_data", memory_data, 32'h78);

    // Reset in the second ACCESS cycle of a LW
    issue(OpLw, 32'h100, 32'h0, 32'd4, 3'd3);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'd0, memory_busy}, 32'd0);
    check_eq("mid_rst_wr", {31'd0, mem_wr}, 32'd0);
    check_eq("mid_rst_des", {29'd0, memory_des_in}, 32'd0);
    check_eq("mid_rst_a", mem_a, 32'd0);
    @(negedge clk); rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (memory_des_in != 3'd0 || memory_busy) seen++;
    end
    check_eq("mid_rst_no_done", seen, 32'd0);

    // SB into the I/O window with io_buffer_full high for three cycles
    @(negedge clk);
    io_buffer_full = 1'b1;
    issue(OpSb, 32'h30000, 32'h000000A5, 32'h0, 3'd4);
`ifdef LSU_IO_STALL_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("io_stall_wr", {31'd0, mem_wr}, 32'd0);
    end
    @(posedge clk);
    #1 io_buffer_full = 1'b0;
    @(negedge clk);
`else
    @(negedge clk);
`endif
    check_eq("io_wr", {31'd0, mem_wr}, 32'd1);
    check_eq("io_a", mem_a, 32'h30000);
    check_eq("io_dout", {24'd0, mem_dout}, 32'hA5);
    wait_done(10, cyc, d, t);
    check_eq("io_done_lat", cyc, 32'd1);
    check_eq("io_done_des", {29'd0, t}, 32'd4);
    io_buffer_full = 1'b0;

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
